// File: rtl/decode_pipe.sv
// Registered RV32I/RV64I decode stage with a main/skid output buffer and flush.
// One cycle latency; full throughput under backpressure; ready_o comes from registered state only.
module decode_pipe #(
  parameter int AWIDTH = 32,
  parameter int XLEN   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [31:0]                    insn_i,
  input  logic [AWIDTH-1:0]              pc_i,
  input  logic                           flush_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [AWIDTH-1:0]              pc_o,
  output logic [31:0]                    insn_o,
  output logic [6:0]                     opcode_o,
  output logic [4:0]                     rd_o,
  output logic [4:0]                     rs1_o,
  output logic [4:0]                     rs2_o,
  output logic [2:0]                     funct3_o,
  output logic [6:0]                     funct7_o,
  output logic [(XLEN == 64 ? 5 : 4):0]  shamt_o,
  output logic [XLEN-1:0]                imm_o,
  output logic                           illegal_o
);

  localparam int SHW  = (XLEN == 64) ? 6 : 5;
  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [31:0]       insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } bundle_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic            wide_shift;
  logic            is_shift;
  logic            shift_ok;
  logic [6:0]      shift_f7;
  logic [SHW-1:0]  sh_amt;
  logic            r_ok;
  bundle_t         dec;
  bundle_t         main_q, skid_q;
  logic            main_vld, skid_vld;
  logic            accept, xfer;

  assign opc = insn_i[6:0];
  assign f3  = insn_i[14:12];
  assign f7  = insn_i[31:25];

  assign imm_i = {{(XLEN-11){insn_i[31]}}, insn_i[30:20]};
  assign imm_s = {{(XLEN-11){insn_i[31]}}, insn_i[30:25], insn_i[11:7]};
  assign imm_b = {{(XLEN-12){insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){insn_i[31]}}, insn_i[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
  assign imm_z = {{(XLEN-12){1'b0}}, insn_i[31:20]};

  // RV64 OP-IMM shifts carry a 6-bit shamt, leaving a 6-bit funct field in insn[31:26].
  assign wide_shift = RV64 && (opc == OPC_OP_IMM);
  assign is_shift   = (f3 == 3'd1) || (f3 == 3'd5);
  assign shift_ok   = wide_shift
                    ? ((insn_i[31:26] == 6'h00) || ((insn_i[31:26] == 6'h10) && (f3 == 3'd5)))
                    : ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd5)));
  assign shift_f7   = wide_shift ? {insn_i[31:26], 1'b0} : f7;
  assign r_ok       = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));

  if (XLEN == 64) begin : g_sh64
    assign sh_amt = wide_shift ? insn_i[25:20] : {1'b0, insn_i[24:20]};
  end else begin : g_sh32
    assign sh_amt = insn_i[24:20];
  end

  always_comb begin
    dec        = '0;
    dec.pc     = pc_i;
    dec.insn   = insn_i;
    dec.opcode = opc;
    case (opc)
      OPC_OP, OPC_OP_32: begin
        dec.rd      = insn_i[11:7];
        dec.rs1     = insn_i[19:15];
        dec.rs2     = insn_i[24:20];
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.illegal = !r_ok || ((opc == OPC_OP_32) && !RV64);
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        dec.rd     = insn_i[11:7];
        dec.rs1    = insn_i[19:15];
        dec.funct3 = f3;
        if (is_shift) begin
          dec.funct7  = shift_f7;
          dec.shamt   = sh_amt;
          dec.imm     = imm_z;
          dec.illegal = !shift_ok;
        end else begin
          dec.imm = imm_i;
        end
        if ((opc == OPC_OP_IMM32) && !RV64) dec.illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec.rd      = insn_i[11:7];
        dec.rs1     = insn_i[19:15];
        dec.funct3  = f3;
        dec.imm     = imm_i;
        dec.illegal = (f3 == 3'd7) || (!RV64 && ((f3 == 3'd3) || (f3 == 3'd6)));
      end
      OPC_STORE: begin
        dec.rs1     = insn_i[19:15];
        dec.rs2     = insn_i[24:20];
        dec.funct3  = f3;
        dec.imm     = imm_s;
        dec.illegal = (f3 > 3'd3) || (!RV64 && (f3 == 3'd3));
      end
      OPC_BRANCH: begin
        dec.rs1     = insn_i[19:15];
        dec.rs2     = insn_i[24:20];
        dec.funct3  = f3;
        dec.imm     = imm_b;
        dec.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_JALR: begin
        dec.rd      = insn_i[11:7];
        dec.rs1     = insn_i[19:15];
        dec.funct3  = f3;
        dec.imm     = imm_i;
        dec.illegal = (f3 != 3'd0);
      end
      OPC_JAL: begin
        dec.rd  = insn_i[11:7];
        dec.imm = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rd  = insn_i[11:7];
        dec.imm = imm_u;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        dec.rd     = insn_i[11:7];
        dec.rs1    = insn_i[19:15];
        dec.funct3 = f3;
        dec.imm    = imm_i;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (insn_i[1:0] != 2'b11) dec.illegal = 1'b1;
    // An illegal word keeps only its identity so downstream can raise the trap.
    if (dec.illegal) begin
      dec         = '0;
      dec.pc      = pc_i;
      dec.insn    = insn_i;
      dec.opcode  = opc;
      dec.illegal = 1'b1;
    end
  end

  assign accept = valid_i && !skid_vld;
  assign xfer   = main_vld && ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush_i) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (xfer) begin
      // Skid full implies no accept this cycle, so the two branches never compete.
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q <= dec;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end
  end

  assign ready_o   = !skid_vld;
  assign valid_o   = main_vld;
  assign pc_o      = main_q.pc;
  assign insn_o    = main_q.insn;
  assign opcode_o  = main_q.opcode;
  assign rd_o      = main_q.rd;
  assign rs1_o     = main_q.rs1;
  assign rs2_o     = main_q.rs2;
  assign funct3_o  = main_q.funct3;
  assign funct7_o  = main_q.funct7;
  assign shamt_o   = main_q.shamt;
  assign imm_o     = main_q.imm;
  assign illegal_o = main_q.illegal;

endmodule
